// File: rtl/bird_pkg.sv
// Shared types and helpers for the bird column tracker.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    DEAD
  } bird_state_t;

  // Width of a row index for a column of h rows.
  function automatic int unsigned row_w(input int unsigned h);
    return $clog2(h);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a pre-synchronised key level.
// One flop of history; the registered copy is updated every cycle.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember the previous key level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bird_column.sv
// Vertical bird tracker for one LED column.
// Optional feature macro: BIRD_CEIL_KILL_EN makes a flap at the ceiling lethal.
module bird_column
  import bird_pkg::*;
#(
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned START_ROW = 4,
  parameter int unsigned FALL_DIV  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flap,
  input  logic                      fall_tick,
  input  logic                      pause,
  output logic [HEIGHT-1:0]         rows,
  output logic [row_w(HEIGHT)-1:0]  row_idx,
  output logic                      alive,
  output logic                      crash
);

  localparam int unsigned RW = row_w(HEIGHT);
  localparam int unsigned CW = row_w(FALL_DIV + 1);

  localparam logic [RW-1:0]     START  = RW'(START_ROW);
  localparam logic [RW-1:0]     TOP    = RW'(HEIGHT - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(FALL_DIV - 1);
  localparam logic [HEIGHT-1:0] ONE    = HEIGHT'(1);

  bird_state_t   state;
  logic [CW-1:0] fall_cnt;
  logic          flap_rise;

  rise_detect u_flap_rise (
    .clk   (clk),
    .reset (reset),
    .d     (flap),
    .rise  (flap_rise)
  );

  // Bird FSM, gravity counter and registered one-hot row drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      row_idx  <= START;
      fall_cnt <= '0;
      alive    <= 1'b0;
      crash    <= 1'b0;
      rows     <= ONE << START;
    end else begin
      crash <= 1'b0;
      case (state)
        IDLE: begin
          if (flap_rise) begin
            state <= FLY;
            alive <= 1'b1;
          end
        end
        FLY: begin
          if (!pause) begin
            if (flap_rise) begin
              fall_cnt <= '0;
`ifdef BIRD_CEIL_KILL_EN
              if (row_idx == TOP) begin
                state <= DEAD;
                alive <= 1'b0;
                crash <= 1'b1;
                rows  <= '0;
              end else begin
                row_idx <= row_idx + 1'b1;
                rows    <= ONE << (row_idx + 1'b1);
              end
`else
              if (row_idx != TOP) begin
                row_idx <= row_idx + 1'b1;
                rows    <= ONE << (row_idx + 1'b1);
              end
`endif
            end else if (fall_tick) begin
              if (fall_cnt == CNT_LAST) begin
                fall_cnt <= '0;
                if (row_idx == '0) begin
                  state <= DEAD;
                  alive <= 1'b0;
                  crash <= 1'b1;
                  rows  <= '0;
                end else begin
                  row_idx <= row_idx - 1'b1;
                  rows    <= ONE << (row_idx - 1'b1);
                end
              end else begin
                fall_cnt <= fall_cnt + 1'b1;
              end
            end
          end
        end
        DEAD: begin
          if (flap_rise) begin
            state    <= IDLE;
            row_idx  <= START;
            fall_cnt <= '0;
            rows     <= ONE << START;
          end
        end
        default: begin
          state <= IDLE;
          alive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_column.sv
// Directed scoreboard bench for bird_column (HEIGHT=8, START_ROW=4, FALL_DIV=2).
module tb_bird_column;

  typedef struct {
    string      tag;
    logic [7:0] rows;
    logic [2:0] row;
    logic       alive;
    logic       crash;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flap;
  logic       fall_tick;
  logic       pause;
  logic [7:0] rows;
  logic [2:0] row_idx;
  logic       alive;
  logic       crash;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];

  bird_column #(
    .HEIGHT    (8),
    .START_ROW (4),
    .FALL_DIV  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flap      (flap),
    .fall_tick (fall_tick),
    .pause     (pause),
    .rows      (rows),
    .row_idx   (row_idx),
    .alive     (alive),
    .crash     (crash)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lit(input int r);
    logic [7:0] v;
    v = 8'h01;
    return v << r;
  endfunction

  task automatic expect_push(input string tag, input int r, input logic [7:0] rv,
                             input logic a, input logic c);
    exp_t e;
    e.tag = tag; e.rows = rv; e.row = 3'(r); e.alive = a; e.crash = c;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checks += 4;
    assert (rows === e.rows) else begin
      errors++; $error("FAIL %s.rows observed=%h expected=%h", e.tag, rows, e.rows);
    end
    assert (row_idx === e.row) else begin
      errors++; $error("FAIL %s.row_idx observed=%0d expected=%0d", e.tag, row_idx, e.row);
    end
    assert (alive === e.alive) else begin
      errors++; $error("FAIL %s.alive observed=%b expected=%b", e.tag, alive, e.alive);
    end
    assert (crash === e.crash) else begin
      errors++; $error("FAIL %s.crash observed=%b expected=%b", e.tag, crash, e.crash);
    end
  endtask

  // Drive inputs, queue the expectation, then compare 1 time unit after the edge.
  task automatic step(input logic f, input logic t, input logic p, input string tag,
                      input int r, input logic [7:0] rv, input logic a, input logic c);
    flap = f; fall_tick = t; pause = p;
    expect_push(tag, r, rv, a, c);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    reset = 1'b0; flap = 1'b0; fall_tick = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
    expect_push("reset", 4, 8'h10, 1'b0, 1'b0);
    check_now();
    reset = 1'b1;

    // Start flying; a held key counts once.
    step(1, 0, 0, "go_fly", 4, lit(4), 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, "hold", 4, lit(4), 1, 0);
    step(0, 0, 0, "release", 4, lit(4), 1, 0);
    step(1, 0, 0, "repress", 5, 8'h20, 1, 0);
    step(0, 0, 0, "rel5", 5, lit(5), 1, 0);
    step(1, 0, 0, "to6", 6, lit(6), 1, 0);

    // Asynchronous reset mid-cycle while flying at row 6.
    #2;
    reset = 1'b0; flap = 1'b0;
    #1;
    expect_push("async_rst", 4, 8'h10, 1'b0, 1'b0);
    check_now();
    @(posedge clk); #1;
    expect_push("rst_held", 4, 8'h10, 1'b0, 1'b0);
    check_now();
    reset = 1'b1;
    step(0, 1, 0, "idle_tick", 4, lit(4), 0, 0);

    // Fly again and descend to row 3 with fall_cnt=1.
    step(1, 0, 0, "fly2", 4, lit(4), 1, 0);
    step(0, 1, 0, "tk_a", 4, lit(4), 1, 0);
    step(0, 1, 0, "tk_b", 3, lit(3), 1, 0);
    step(0, 1, 0, "tk_c", 3, lit(3), 1, 0);

    // Flap and tick together: flap wins and clears the gravity count.
    step(1, 1, 0, "flap_tick", 4, lit(4), 1, 0);
    step(0, 1, 0, "cnt_cleared", 4, lit(4), 1, 0);
    step(0, 1, 0, "cnt_wrap", 3, lit(3), 1, 0);
    step(0, 1, 0, "tk_d", 3, lit(3), 1, 0);
    step(0, 1, 0, "at2", 2, lit(2), 1, 0);

    // Fall to the floor and crash.
    step(0, 1, 0, "fall1", 2, lit(2), 1, 0);
    step(0, 1, 0, "fall2", 1, lit(1), 1, 0);
    step(0, 1, 0, "fall3", 1, lit(1), 1, 0);
    step(0, 1, 0, "floor", 0, 8'h01, 1, 0);
    step(0, 1, 0, "floor_cnt", 0, 8'h01, 1, 0);
    step(0, 1, 0, "crash", 0, 8'h00, 0, 1);
    step(0, 0, 0, "crash_once", 0, 8'h00, 0, 0);
    step(0, 1, 0, "dead_tick", 0, 8'h00, 0, 0);

    // Restart from DEAD.
    step(1, 0, 0, "restart", 4, 8'h10, 0, 0);
    step(0, 0, 0, "idle_wait", 4, lit(4), 0, 0);
    step(1, 0, 0, "fly3", 4, lit(4), 1, 0);
    step(0, 1, 0, "pre_pause", 4, lit(4), 1, 0);

    // Pause drops flaps and ticks and keeps the gravity count.
    step(1, 0, 1, "pause_flap", 4, lit(4), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, "pause_tick", 4, lit(4), 1, 0);
    step(0, 1, 0, "unpause_tick", 3, lit(3), 1, 0);

    // Climb to the ceiling.
    step(1, 0, 0, "up4", 4, lit(4), 1, 0);
    step(0, 0, 0, "r4", 4, lit(4), 1, 0);
    step(1, 0, 0, "up5", 5, lit(5), 1, 0);
    step(0, 0, 0, "r5", 5, lit(5), 1, 0);
    step(1, 0, 0, "up6", 6, lit(6), 1, 0);
    step(0, 0, 0, "r6", 6, lit(6), 1, 0);
    step(1, 0, 0, "up7", 7, lit(7), 1, 0);
    step(0, 1, 0, "top_tick", 7, lit(7), 1, 0);
`ifdef BIRD_CEIL_KILL_EN
    step(1, 0, 0, "ceil_kill", 7, 8'h00, 0, 1);
    step(0, 0, 0, "ceil_dead", 7, 8'h00, 0, 0);
    step(1, 0, 0, "ceil_restart", 4, 8'h10, 0, 0);
`else
    step(1, 0, 0, "ceil_sat", 7, 8'h80, 1, 0);
    step(0, 0, 0, "ceil_rel", 7, lit(7), 1, 0);
    step(1, 0, 0, "ceil_sat2", 7, lit(7), 1, 0);
    step(0, 1, 0, "ceil_cnt", 7, lit(7), 1, 0);
    step(0, 1, 0, "ceil_fall", 6, lit(6), 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
